// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI-Lite SDRAM arbiter.
package axil_arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4
   } arb_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first requester at or after rr_ptr, wrapping to the lowest requester.
module rr_priority_picker #(
   parameter  int unsigned NUM_REQ   = 2,
   localparam int unsigned IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [IDX_WIDTH-1:0] rr_ptr,
   output logic                 found,
   output logic [IDX_WIDTH-1:0] idx
);

   logic                 hi_found;
   logic [IDX_WIDTH-1:0] hi_idx;
   logic [IDX_WIDTH-1:0] lo_idx;

   // Descending scan so the last hit is the lowest index in each region
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int unsigned i = NUM_REQ; i > 0; i--) begin
         if (req[i-1]) begin
            lo_idx = IDX_WIDTH'(i - 1);
            if (IDX_WIDTH'(i - 1) >= rr_ptr) begin
               hi_found = 1'b1;
               hi_idx   = IDX_WIDTH'(i - 1);
            end
         end
      end
      found = |req;
      idx   = hi_found ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/axil_sdram_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite SDRAM slave port among several masters,
// one transaction in flight, combinational forwarding to/from the granted master.
module axil_sdram_arbiter
   import axil_arb_pkg::*;
#(
   parameter  int unsigned NUM_MASTERS = 2,
   parameter  int unsigned ADDR_WIDTH  = 32,
   parameter  int unsigned DATA_WIDTH  = 32,
   parameter  int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
   localparam int unsigned IDX_WIDTH   = $clog2(NUM_MASTERS)
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   // upstream masters
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [NUM_MASTERS-1:0]            s_axil_awvalid,
   output logic [NUM_MASTERS-1:0]            s_axil_awready,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [NUM_MASTERS*STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic [NUM_MASTERS-1:0]            s_axil_wvalid,
   output logic [NUM_MASTERS-1:0]            s_axil_wready,
   output logic [NUM_MASTERS*2-1:0]          s_axil_bresp,
   output logic [NUM_MASTERS-1:0]            s_axil_bvalid,
   input  logic [NUM_MASTERS-1:0]            s_axil_bready,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [NUM_MASTERS-1:0]            s_axil_arvalid,
   output logic [NUM_MASTERS-1:0]            s_axil_arready,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_axil_rdata,
   output logic [NUM_MASTERS*2-1:0]          s_axil_rresp,
   output logic [NUM_MASTERS-1:0]            s_axil_rvalid,
   input  logic [NUM_MASTERS-1:0]            s_axil_rready,
   // downstream SDRAM controller
   output logic [ADDR_WIDTH-1:0]             m_axil_awaddr,
   output logic [2:0]                        m_axil_awprot,
   output logic                              m_axil_awvalid,
   input  logic                              m_axil_awready,
   output logic [DATA_WIDTH-1:0]             m_axil_wdata,
   output logic [STRB_WIDTH-1:0]             m_axil_wstrb,
   output logic                              m_axil_wvalid,
   input  logic                              m_axil_wready,
   input  logic [1:0]                        m_axil_bresp,
   input  logic                              m_axil_bvalid,
   output logic                              m_axil_bready,
   output logic [ADDR_WIDTH-1:0]             m_axil_araddr,
   output logic [2:0]                        m_axil_arprot,
   output logic                              m_axil_arvalid,
   input  logic                              m_axil_arready,
   input  logic [DATA_WIDTH-1:0]             m_axil_rdata,
   input  logic [1:0]                        m_axil_rresp,
   input  logic                              m_axil_rvalid,
   output logic                              m_axil_rready,
   // status
   output logic [IDX_WIDTH-1:0]              grant_idx,
   output logic                              busy
);

   arb_state_t           state, state_n;
   logic [IDX_WIDTH-1:0] grant_n;
   logic [IDX_WIDTH-1:0] rr_ptr, rr_ptr_n;
   logic                 aw_done, aw_done_n;
   logic                 w_done, w_done_n;

   logic [NUM_MASTERS-1:0] req;
   logic                   pick_found;
   logic [IDX_WIDTH-1:0]   pick_idx;
   logic [IDX_WIDTH-1:0]   next_ptr;

   // granted master's request-side signals
   logic [ADDR_WIDTH-1:0] g_awaddr;
   logic                  g_awvalid;
   logic [DATA_WIDTH-1:0] g_wdata;
   logic [STRB_WIDTH-1:0] g_wstrb;
   logic                  g_wvalid;
   logic                  g_bready;
   logic [ADDR_WIDTH-1:0] g_araddr;
   logic                  g_arvalid;
   logic                  g_rready;

   // response-side signals heading back to the granted master
   logic                  up_awready;
   logic                  up_wready;
   logic                  up_bvalid;
   logic [1:0]            up_bresp;
   logic                  up_arready;
   logic                  up_rvalid;
   logic [DATA_WIDTH-1:0] up_rdata;
   logic [1:0]            up_rresp;
   logic                  aw_hs;
   logic                  w_hs;

   assign req      = s_axil_awvalid | s_axil_arvalid;
   assign busy     = (state != IDLE);
   assign next_ptr = (grant_idx == IDX_WIDTH'(NUM_MASTERS - 1)) ? '0 : IDX_WIDTH'(grant_idx + 1'b1);

   rr_priority_picker #(
      .NUM_REQ (NUM_MASTERS)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   // State, grant and round-robin pointer registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         grant_idx <= '0;
         rr_ptr    <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         state     <= state_n;
         grant_idx <= grant_n;
         rr_ptr    <= rr_ptr_n;
         aw_done   <= aw_done_n;
         w_done    <= w_done_n;
      end
   end

   // Next-state logic plus combinational forwarding between granted master and downstream
   always_comb begin
      state_n   = state;
      grant_n   = grant_idx;
      rr_ptr_n  = rr_ptr;
      aw_done_n = aw_done;
      w_done_n  = w_done;

      m_axil_awaddr  = '0;
      m_axil_awprot  = 3'b000;
      m_axil_awvalid = 1'b0;
      m_axil_wdata   = '0;
      m_axil_wstrb   = '0;
      m_axil_wvalid  = 1'b0;
      m_axil_bready  = 1'b0;
      m_axil_araddr  = '0;
      m_axil_arprot  = 3'b000;
      m_axil_arvalid = 1'b0;
      m_axil_rready  = 1'b0;

      s_axil_awready = '0;
      s_axil_wready  = '0;
      s_axil_bresp   = '0;
      s_axil_bvalid  = '0;
      s_axil_arready = '0;
      s_axil_rdata   = '0;
      s_axil_rresp   = '0;
      s_axil_rvalid  = '0;

      g_awaddr  = '0;
      g_awvalid = 1'b0;
      g_wdata   = '0;
      g_wstrb   = '0;
      g_wvalid  = 1'b0;
      g_bready  = 1'b0;
      g_araddr  = '0;
      g_arvalid = 1'b0;
      g_rready  = 1'b0;

      up_awready = 1'b0;
      up_wready  = 1'b0;
      up_bvalid  = 1'b0;
      up_bresp   = AXI_RESP_OKAY;
      up_arready = 1'b0;
      up_rvalid  = 1'b0;
      up_rdata   = '0;
      up_rresp   = AXI_RESP_OKAY;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;

      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (grant_idx == IDX_WIDTH'(i)) begin
            g_awaddr  = s_axil_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            g_awvalid = s_axil_awvalid[i];
            g_wdata   = s_axil_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            g_wstrb   = s_axil_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
            g_wvalid  = s_axil_wvalid[i];
            g_bready  = s_axil_bready[i];
            g_araddr  = s_axil_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            g_arvalid = s_axil_arvalid[i];
            g_rready  = s_axil_rready[i];
         end
      end

      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_n = pick_idx;
               state_n = s_axil_awvalid[pick_idx] ? WR_ADDR : RD_ADDR;
            end
         end
         WR_ADDR: begin
            m_axil_awaddr  = g_awaddr;
            m_axil_awvalid = g_awvalid & ~aw_done;
            m_axil_wdata   = g_wdata;
            m_axil_wstrb   = g_wstrb;
            m_axil_wvalid  = g_wvalid & ~w_done;
            up_awready     = m_axil_awready & ~aw_done;
            up_wready      = m_axil_wready & ~w_done;
            aw_hs          = m_axil_awvalid & m_axil_awready;
            w_hs           = m_axil_wvalid & m_axil_wready;
            if ((aw_done | aw_hs) & (w_done | w_hs)) begin
               aw_done_n = 1'b0;
               w_done_n  = 1'b0;
               state_n   = WR_RESP;
            end else begin
               aw_done_n = aw_done | aw_hs;
               w_done_n  = w_done | w_hs;
            end
         end
         WR_RESP: begin
            up_bvalid     = m_axil_bvalid;
            up_bresp      = m_axil_bresp;
            m_axil_bready = g_bready;
            if (m_axil_bvalid & g_bready) begin
               rr_ptr_n = next_ptr;
               state_n  = IDLE;
            end
         end
         RD_ADDR: begin
            m_axil_araddr  = g_araddr;
            m_axil_arvalid = g_arvalid;
            up_arready     = m_axil_arready;
            if (g_arvalid & m_axil_arready) begin
               state_n = RD_DATA;
            end
         end
         RD_DATA: begin
            up_rvalid     = m_axil_rvalid;
            up_rdata      = m_axil_rdata;
            up_rresp      = m_axil_rresp;
            m_axil_rready = g_rready;
            if (m_axil_rvalid & g_rready) begin
               rr_ptr_n = next_ptr;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (grant_idx == IDX_WIDTH'(i)) begin
            s_axil_awready[i]                        = up_awready;
            s_axil_wready[i]                         = up_wready;
            s_axil_bvalid[i]                         = up_bvalid;
            s_axil_bresp[i*2 +: 2]                   = up_bresp;
            s_axil_arready[i]                        = up_arready;
            s_axil_rvalid[i]                         = up_rvalid;
            s_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH] = up_rdata;
            s_axil_rresp[i*2 +: 2]                   = up_rresp;
         end
      end
   end

endmodule

// File: tb/tb_axil_sdram_arbiter.sv
// Directed bench for axil_sdram_arbiter with two masters and a simple downstream memory model.
module tb_axil_sdram_arbiter;
   import axil_arb_pkg::*;

   localparam int unsigned NM = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;

   logic [NM*AW-1:0] s_axil_awaddr  = '0;
   logic [NM-1:0]    s_axil_awvalid = '0;
   logic [NM-1:0]    s_axil_awready;
   logic [NM*DW-1:0] s_axil_wdata   = '0;
   logic [NM*SW-1:0] s_axil_wstrb   = '0;
   logic [NM-1:0]    s_axil_wvalid  = '0;
   logic [NM-1:0]    s_axil_wready;
   logic [NM*2-1:0]  s_axil_bresp;
   logic [NM-1:0]    s_axil_bvalid;
   logic [NM-1:0]    s_axil_bready  = '0;
   logic [NM*AW-1:0] s_axil_araddr  = '0;
   logic [NM-1:0]    s_axil_arvalid = '0;
   logic [NM-1:0]    s_axil_arready;
   logic [NM*DW-1:0] s_axil_rdata;
   logic [NM*2-1:0]  s_axil_rresp;
   logic [NM-1:0]    s_axil_rvalid;
   logic [NM-1:0]    s_axil_rready  = '0;

   logic [AW-1:0] m_axil_awaddr;
   logic [2:0]    m_axil_awprot;
   logic          m_axil_awvalid;
   logic          m_axil_awready = 1'b0;
   logic [DW-1:0] m_axil_wdata;
   logic [SW-1:0] m_axil_wstrb;
   logic          m_axil_wvalid;
   logic          m_axil_wready  = 1'b0;
   logic [1:0]    m_axil_bresp   = 2'b00;
   logic          m_axil_bvalid  = 1'b0;
   logic          m_axil_bready;
   logic [AW-1:0] m_axil_araddr;
   logic [2:0]    m_axil_arprot;
   logic          m_axil_arvalid;
   logic          m_axil_arready = 1'b0;
   logic [DW-1:0] m_axil_rdata   = '0;
   logic [1:0]    m_axil_rresp   = 2'b00;
   logic          m_axil_rvalid  = 1'b0;
   logic          m_axil_rready;
   logic [0:0]    grant_idx;
   logic          busy;

   axil_sdram_arbiter #(
      .NUM_MASTERS (NM),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
      .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
      .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
      .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
      .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
      .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
      .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
      .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr),
      .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
      .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
      .m_axil_rready(m_axil_rready),
      .grant_idx(grant_idx), .busy(busy)
   );

   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Downstream memory model and handshake monitor
   logic [31:0] mem [0:15] = '{default: 32'h0};
   logic [1:0]  sl_bresp = AXI_RESP_OKAY;
   logic        sl_aw_got = 1'b0, sl_w_got = 1'b0;
   logic [31:0] sl_awaddr = '0, sl_wdata = '0;
   logic [3:0]  sl_wstrb = '0;
   logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;
   logic [31:0] last_awaddr = '0, last_wdata = '0;
   logic [3:0]  last_wstrb = '0;
   int          cyc = 0;
   int          ar_q[$];
   int          ar_t[$];
   int          aw_q[$];
   int          rv1_cnt = 0;

   always @(posedge aclk) begin
      cyc++;
      hs_aw = m_axil_awvalid & m_axil_awready;
      hs_w  = m_axil_wvalid & m_axil_wready;
      hs_b  = m_axil_bvalid & m_axil_bready;
      hs_ar = m_axil_arvalid & m_axil_arready;
      hs_r  = m_axil_rvalid & m_axil_rready;
      cap_awaddr = m_axil_awaddr;
      cap_wdata  = m_axil_wdata;
      cap_wstrb  = m_axil_wstrb;
      cap_araddr = m_axil_araddr;
      if (hs_ar) begin
         ar_q.push_back(int'(grant_idx));
         ar_t.push_back(cyc);
      end
      if (hs_aw) aw_q.push_back(int'(grant_idx));
      #1;
      if (!aresetn) begin
         sl_aw_got     = 1'b0;
         sl_w_got      = 1'b0;
         m_axil_bvalid = 1'b0;
         m_axil_rvalid = 1'b0;
      end else begin
         if (hs_aw) begin sl_aw_got = 1'b1; sl_awaddr = cap_awaddr; last_awaddr = cap_awaddr; end
         if (hs_w) begin
            sl_w_got = 1'b1; sl_wdata = cap_wdata; sl_wstrb = cap_wstrb;
            last_wdata = cap_wdata; last_wstrb = cap_wstrb;
         end
         if (hs_b) m_axil_bvalid = 1'b0;
         if (sl_aw_got && sl_w_got && !m_axil_bvalid) begin
            for (int b = 0; b < 4; b++)
               if (sl_wstrb[b]) mem[sl_awaddr[5:2]][b*8 +: 8] = sl_wdata[b*8 +: 8];
            m_axil_bvalid = 1'b1;
            m_axil_bresp  = sl_bresp;
            sl_aw_got = 1'b0;
            sl_w_got  = 1'b0;
         end
         if (hs_r) m_axil_rvalid = 1'b0;
         if (hs_ar) begin
            m_axil_rvalid = 1'b1;
            m_axil_rdata  = mem[cap_araddr[5:2]];
            m_axil_rresp  = AXI_RESP_OKAY;
         end
      end
      m_axil_awready = !sl_aw_got && !m_axil_bvalid;
      m_axil_wready  = !sl_w_got && !m_axil_bvalid;
      m_axil_arready = !m_axil_rvalid;
   end

   always @(negedge aclk) if (s_axil_rvalid[1]) rv1_cnt++;

   task automatic do_reset();
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
   endtask

   task automatic do_read(input int m, input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n;
      s_axil_araddr[m*AW +: AW] = addr;
      s_axil_arvalid[m] = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!s_axil_arready[m] && n < 200);
      check($sformatf("m%0d arready", m), 64'(s_axil_arready[m]), 64'd1);
      @(posedge aclk); #1;
      s_axil_arvalid[m] = 1'b0;
      s_axil_rready[m]  = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!s_axil_rvalid[m] && n < 200);
      check($sformatf("m%0d rvalid", m), 64'(s_axil_rvalid[m]), 64'd1);
      data = s_axil_rdata[m*DW +: DW];
      resp = s_axil_rresp[m*2 +: 2];
      @(posedge aclk); #1;
      s_axil_rready[m] = 1'b0;
   endtask

   task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      int   n;
      logic a, b, aw_ok, w_ok;
      s_axil_awaddr[m*AW +: AW] = addr;
      s_axil_wdata[m*DW +: DW]  = data;
      s_axil_wstrb[m*SW +: SW]  = strb;
      s_axil_awvalid[m] = 1'b1;
      s_axil_wvalid[m]  = 1'b1;
      aw_ok = 1'b0; w_ok = 1'b0; n = 0;
      while (!(aw_ok && w_ok) && n < 200) begin
         @(negedge aclk); n++;
         a = s_axil_awvalid[m] & s_axil_awready[m];
         b = s_axil_wvalid[m] & s_axil_wready[m];
         @(posedge aclk); #1;
         if (a) begin aw_ok = 1'b1; s_axil_awvalid[m] = 1'b0; end
         if (b) begin w_ok = 1'b1; s_axil_wvalid[m] = 1'b0; end
      end
      check($sformatf("m%0d aw+w accepted", m), 64'({aw_ok, w_ok}), 64'd3);
      s_axil_bready[m] = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!s_axil_bvalid[m] && n < 200);
      check($sformatf("m%0d bvalid", m), 64'(s_axil_bvalid[m]), 64'd1);
      resp = s_axil_bresp[m*2 +: 2];
      @(posedge aclk); #1;
      s_axil_bready[m] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] d0, d1;
      logic [1:0]  r0, r1, rw;
      int          base, awbase, rvb;

      // Reset state
      #2;
      check("rst busy", 64'(busy), 64'd0);
      check("rst grant_idx", 64'(grant_idx), 64'd0);
      check("rst m valids", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready}), 64'd0);
      check("rst s readies", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'd0);
      check("rst s valids", 64'({s_axil_bvalid, s_axil_rvalid}), 64'd0);
      do_reset();

      // Single master write then read
      awbase = aw_q.size();
      rvb    = rv1_cnt;
      do_write(0, 32'h100, 32'hDEADBEEF, 4'hF, rw);
      check("t1 bresp", 64'(rw), 64'(AXI_RESP_OKAY));
      check("t1 m_awaddr", 64'(last_awaddr), 64'h100);
      check("t1 m_wdata", 64'(last_wdata), 64'hDEADBEEF);
      check("t1 m_wstrb", 64'(last_wstrb), 64'hF);
      check("t1 aw grant", 64'(aw_q[awbase]), 64'd0);
      check("t1 awprot", 64'(m_axil_awprot), 64'd0);
      do_read(0, 32'h100, d0, r0);
      check("t1 rdata", 64'(d0), 64'hDEADBEEF);
      check("t1 rresp", 64'(r0), 64'(AXI_RESP_OKAY));
      check("t1 m1 rvalid never", 64'(rv1_cnt - rvb), 64'd0);

      // Simultaneous reads after reset: master 0 first, then master 1
      do_reset();
      base = ar_q.size();
      fork
         do_read(0, 32'h100, d0, r0);
         do_read(1, 32'h100, d1, r1);
      join
      check("t2 first grant", 64'(ar_q[base]), 64'd0);
      check("t2 second grant", 64'(ar_q[base+1]), 64'd1);
      check("t2 ar spacing", 64'(ar_t[base+1] - ar_t[base]), 64'd3);
      check("t2 m0 rdata", 64'(d0), 64'hDEADBEEF);
      check("t2 m1 rdata", 64'(d1), 64'hDEADBEEF);

      // Continuous reads from both masters: strict alternation
      base = ar_q.size();
      fork
         begin for (int k = 0; k < 4; k++) do_read(0, 32'h100, d0, r0); end
         begin for (int k = 0; k < 4; k++) do_read(1, 32'h100, d1, r1); end
      join
      check("t3 ar count", 64'(ar_q.size() - base), 64'd8);
      for (int k = 0; k < 8; k++)
         check($sformatf("t3 grant %0d", k), 64'(ar_q[base+k]), 64'(k % 2));

      // Master 1: AW three cycles ahead of W, SLVERR passed through
      sl_bresp = AXI_RESP_SLVERR;
      awbase = aw_q.size();
      s_axil_awaddr[1*AW +: AW] = 32'h100;
      s_axil_awvalid[1] = 1'b1;
      @(negedge aclk);
      check("t4 idle awready", 64'(s_axil_awready[1]), 64'd0);
      @(posedge aclk); #1;
      check("t4 state WR_ADDR", 64'(dut.state), 64'(WR_ADDR));
      @(negedge aclk);
      check("t4 m_awvalid", 64'(m_axil_awvalid), 64'd1);
      check("t4 m_wvalid early", 64'(m_axil_wvalid), 64'd0);
      check("t4 s_awready", 64'(s_axil_awready[1]), 64'd1);
      @(posedge aclk); #1;
      s_axil_awvalid[1] = 1'b0;
      @(negedge aclk);
      check("t4 m_awvalid after accept", 64'(m_axil_awvalid), 64'd0);
      check("t4 still WR_ADDR", 64'(dut.state), 64'(WR_ADDR));
      check("t4 no bvalid yet", 64'(s_axil_bvalid[1]), 64'd0);
      @(posedge aclk); #1;
      s_axil_wdata[1*DW +: DW] = 32'h12345678;
      s_axil_wstrb[1*SW +: SW] = 4'b0011;
      s_axil_wvalid[1] = 1'b1;
      @(negedge aclk);
      check("t4 m_wvalid", 64'(m_axil_wvalid), 64'd1);
      check("t4 m_wdata", 64'(m_axil_wdata), 64'h12345678);
      check("t4 WR_ADDR until W", 64'(dut.state), 64'(WR_ADDR));
      @(posedge aclk); #1;
      s_axil_wvalid[1] = 1'b0;
      s_axil_bready[1] = 1'b1;
      check("t4 state WR_RESP", 64'(dut.state), 64'(WR_RESP));
      @(negedge aclk);
      check("t4 s_bvalid m1", 64'(s_axil_bvalid[1]), 64'd1);
      check("t4 s_bresp m1", 64'(s_axil_bresp[3:2]), 64'(AXI_RESP_SLVERR));
      check("t4 s_bvalid m0", 64'(s_axil_bvalid[0]), 64'd0);
      @(posedge aclk); #1;
      s_axil_bready[1] = 1'b0;
      check("t4 busy after", 64'(busy), 64'd0);
      check("t4 grant_idx", 64'(grant_idx), 64'd1);
      check("t4 aw grant", 64'(aw_q[awbase]), 64'd1);
      sl_bresp = AXI_RESP_OKAY;

      // Master 0 write+read together, master 1 read: write, then m1 read, then m0 read
      awbase = aw_q.size();
      base   = ar_q.size();
      fork
         do_write(0, 32'h104, 32'hCAFEF00D, 4'hF, rw);
         do_read(0, 32'h100, d0, r0);
         do_read(1, 32'h104, d1, r1);
      join
      check("t5 write first", 64'(aw_q[awbase]), 64'd0);
      check("t5 write before reads", 64'(ar_q.size() - base), 64'd2);
      check("t5 read order 0", 64'(ar_q[base]), 64'd1);
      check("t5 read order 1", 64'(ar_q[base+1]), 64'd0);
      check("t5 m0 rdata strobed", 64'(d0), 64'hDEAD5678);
      check("t5 m1 rdata", 64'(d1), 64'hCAFEF00D);
      check("t5 bresp", 64'(rw), 64'(AXI_RESP_OKAY));

      // Asynchronous reset during RD_DATA
      s_axil_araddr[1*AW +: AW] = 32'h104;
      s_axil_arvalid[1] = 1'b1;
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      s_axil_arvalid[1] = 1'b0;
      @(negedge aclk);
      check("t6 rvalid before rst", 64'(s_axil_rvalid[1]), 64'd1);
      check("t6 grant before rst", 64'(grant_idx), 64'd1);
      check("t6 state RD_DATA", 64'(dut.state), 64'(RD_DATA));
      #2 aresetn = 1'b0;
      #1;
      check("t6 s_rvalid async", 64'(s_axil_rvalid), 64'd0);
      check("t6 m_rready async", 64'(m_axil_rready), 64'd0);
      check("t6 busy async", 64'(busy), 64'd0);
      check("t6 grant async", 64'(grant_idx), 64'd0);
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(negedge aclk);
      check("t6 state IDLE", 64'(dut.state), 64'(IDLE));
      check("t6 busy released", 64'(busy), 64'd0);
      check("t6 grant released", 64'(grant_idx), 64'd0);
      check("t6 valids released", 64'({s_axil_rvalid, s_axil_bvalid, m_axil_arvalid, m_axil_awvalid}), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axil_sdram_arbiter.md
Name: axil_sdram_arbiter

Overview:
- Round-robin arbiter that shares the single AXI-Lite SDRAM slave port between NUM_MASTERS AXI-Lite masters, for example the CPU data port, the CPU instruction fetch port and the framebuffer/DMA reader.
- Sits between the masters and the AXI-Lite SDRAM controller wrapper, in the same clock domain.
- Only one transaction (read or write) is in flight at a time, because the SDRAM controller serialises accesses anyway.
- Responses are routed back to the granted master only.

Parameters:
- NUM_MASTERS, 2, number of upstream masters (2..8).
- ADDR_WIDTH, 32, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
- IDX_WIDTH, $clog2(NUM_MASTERS), grant index width (derived, not overridable).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axil_awaddr  in  NUM_MASTERS*ADDR_WIDTH  packed per master; master i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_axil_awvalid / s_axil_awready  in / out  NUM_MASTERS
- s_axil_wdata  in  NUM_MASTERS*DATA_WIDTH
- s_axil_wstrb  in  NUM_MASTERS*STRB_WIDTH
- s_axil_wvalid / s_axil_wready  in / out  NUM_MASTERS
- s_axil_bresp  out  NUM_MASTERS*2
- s_axil_bvalid / s_axil_bready  out / in  NUM_MASTERS
- s_axil_araddr  in  NUM_MASTERS*ADDR_WIDTH
- s_axil_arvalid / s_axil_arready  in / out  NUM_MASTERS
- s_axil_rdata  out  NUM_MASTERS*DATA_WIDTH
- s_axil_rresp  out  NUM_MASTERS*2
- s_axil_rvalid / s_axil_rready  out / in  NUM_MASTERS
- m_axil_awaddr, awvalid / awready, wdata, wstrb, wvalid / wready, bresp, bvalid / bready, araddr, arvalid / arready, rdata, rresp, rvalid / rready
  - Downstream single AXI-Lite master port toward the SDRAM controller; standard directions and widths.
  - awprot and arprot are driven 3'b000.
- grant_idx  out  IDX_WIDTH  current or last granted master (debug/perf)
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (aresetn low, asynchronous):
  - state is IDLE, grant_idx is 0, rr_ptr is 0, aw_done and w_done are 0.
  - Every s_* and m_* valid/ready output is 0; busy is 0.
  - Data and address outputs are don't-care but are driven 0.
- Request vector: req[i] = s_axil_awvalid[i] | s_axil_arvalid[i].
- IDLE:
  - If any req is set, pick the first requesting master at or after rr_ptr, scanning modulo NUM_MASTERS.
  - Register its index into grant_idx.
  - If that master has awvalid set, go to WR_ADDR (write wins over a simultaneous read from the same master); otherwise go to RD_ADDR.
  - The arbitration decision takes 1 cycle. No upstream ready is asserted in IDLE.
- WR_ADDR (AW and W forwarded independently):
  - m_awvalid = s_awvalid[g] & ~aw_done.
  - m_wvalid = s_wvalid[g] & ~w_done.
  - s_awready[g] = m_awready & ~aw_done; s_wready[g] works the same way.
  - Addr, data and strobe are muxed combinationally from master g.
  - aw_done or w_done sets on the respective handshake.
  - When both are done (the same-cycle handshake counts), clear both flags and go to WR_RESP.
- WR_RESP:
  - s_bvalid[g] = m_bvalid, s_bresp[g] = m_bresp, m_bready = s_bready[g].
  - On the handshake, set rr_ptr = (g+1) mod NUM_MASTERS and go to IDLE.
- RD_ADDR:
  - m_arvalid = s_arvalid[g], s_arready[g] = m_arready.
  - On the handshake, go to RD_DATA.
- RD_DATA:
  - s_rvalid[g], s_rdata[g] and s_rresp[g] come from m_*; m_rready = s_rready[g].
  - On the handshake, set rr_ptr = g+1 (mod) and go to IDLE.
- Non-granted masters always see ready = 0 and valid = 0. Their bus lines are driven 0.
- Combinational paths:
  - Forwarding uses no extra register stage, so there are valid→valid and ready→ready combinational paths through the arbiter.
  - Latency added per transaction is exactly 1 cycle (IDLE arbitration) plus 1 cycle return to IDLE.
- Fairness: rr_ptr advances only on transaction completion. A continuously requesting master waits at most NUM_MASTERS-1 transactions.
- Corner cases:
  - A master dropping awvalid before grant is a protocol violation of the master and is not handled.
  - A downstream SLVERR/DECERR is passed through unchanged.
  - Reset mid-transaction abandons it. The downstream controller shares aresetn, so no orphan response is expected.

Decomposition:
- Package axil_arb_pkg:
  - typedef enum logic [2:0] arb_state_t {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA}.
  - Constants AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10.
- One sub-module, rr_priority_picker: combinational; inputs req vector and rr_ptr; outputs found and idx. Reusable by future arbiters.

Test Plan:
- Single master 0 writes 0xDEADBEEF to 0x100 (wstrb 0xF), then reads 0x100 → m_aw/w forwarded with the same values, bresp 2'b00 to master 0, read returns 0xDEADBEEF to master 0 only; master 1 rvalid stays 0 throughout.
- Masters 0 and 1 both assert arvalid in the same cycle after reset → master 0 is served first, then master 1; grant_idx sequence 0,1; each read costs 2 cycles of overhead beyond the downstream latency.
- Both masters issue back-to-back reads continuously for 8 transactions → strict alternation 0,1,0,1…; neither master waits more than 1 transaction.
- Master 1 asserts awvalid 3 cycles before wvalid, downstream takes AW first → m_awvalid drops after AW accept; WR_RESP is entered only after W accepts.
- Master 0 asserts both awvalid and arvalid simultaneously → write served first, read next time the master wins arbitration.
- aresetn pulled low during RD_DATA, with m_rvalid high and s_rready low → all valids drop to 0 without waiting for aclk; after release, state is IDLE, busy is 0, grant_idx is 0.
